// File: rtl/serial_tx_sched_pkg.sv
// Shared types and sizing helpers for the round-robin serial transmit scheduler.
package serial_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    // Bit counter covers WIDTH up to 32; gap counter covers GAP up to 15.
    localparam int CNT_W     = 5;
    localparam int GAP_CNT_W = 4;

    function automatic int gid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_sched_if.sv
// Parallel requester bus: per-requester valid/data with a one-hot ready strobe.
interface serial_tx_sched_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/serial_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter; the last-grant pointer is held by the parent.
module rr_arbiter
    import serial_tx_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [gid_w(N_REQ)-1:0] last,
    input  logic                    en,
    output logic [N_REQ-1:0]        grant,
    output logic [gid_w(N_REQ)-1:0] grant_idx
);
    localparam int IDX_W = gid_w(N_REQ);

    int   idx;
    logic found;

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = last;
        found     = 1'b0;
        idx       = 0;
        // Search starts just past the previous winner and wraps around.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx[IDX_W-1:0];
            end
        end
    end
endmodule

// File: rtl/serial_tx_sched.sv
// Shares one MSB-first serial shift-out path among N_REQ requesters, round-robin,
// with a fixed idle gap after every frame.
module serial_tx_sched
    import serial_tx_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_tx_sched_if.slave        bus,
    output logic                    so,
    output logic                    so_en,
    output logic                    busy,
    output logic [gid_w(N_REQ)-1:0] grant_id,
    output logic                    frame_done
);
    localparam int IDX_W = gid_w(N_REQ);

    state_t               state;
    logic [WIDTH-1:0]     sreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic [N_REQ-1:0]     grant;
    logic [IDX_W-1:0]     win_idx;
    logic [WIDTH-1:0]     win_word;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (bus.req_valid),
        .last      (grant_id),
        .en        (state == ST_IDLE),
        .grant     (grant),
        .grant_idx (win_idx)
    );

    assign bus.req_ready = grant;
    assign win_word      = bus.req_data[win_idx*WIDTH +: WIDTH];

    // NOTE: sequential state uses non-blocking assignments only, and the shift
    // register is reset with everything else so a mid-frame reset drops the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            so         <= 1'b0;
            so_en      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            grant_id   <= IDX_W'(N_REQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        // MSB goes straight to the output register; sreg holds the rest.
                        so       <= win_word[WIDTH-1];
                        sreg     <= win_word << 1;
                        so_en    <= 1'b1;
                        busy     <= 1'b1;
                        grant_id <= win_idx;
                        bit_cnt  <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        so         <= 1'b0;
                        so_en      <= 1'b0;
                        frame_done <= 1'b0;
                        gap_cnt    <= '0;
                        if (GAP > 0) begin
                            state <= ST_GAP;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        so         <= sreg[WIDTH-1];
                        sreg       <= {sreg[WIDTH-2:0], 1'b0};
                        bit_cnt    <= bit_cnt + 1'b1;
                        frame_done <= (bit_cnt == CNT_W'(WIDTH - 2));
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_CNT_W'(GAP - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_tx_sched.sv
// Directed bench: default instance (N_REQ=4, WIDTH=8, GAP=1) plus a WIDTH=4, GAP=0 instance.
module tb_serial_tx_sched;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    serial_tx_sched_if #(.N_REQ(4), .WIDTH(8)) bus1 ();
    serial_tx_sched_if #(.N_REQ(4), .WIDTH(4)) bus2 ();

    logic       so1, so_en1, busy1, fd1;
    logic [1:0] gid1;
    logic       so2, so_en2, busy2, fd2;
    logic [1:0] gid2;

    serial_tx_sched #(.N_REQ(4), .WIDTH(8), .GAP(1)) dut (
        .clk(clk), .reset(reset), .bus(bus1.slave),
        .so(so1), .so_en(so_en1), .busy(busy1), .grant_id(gid1), .frame_done(fd1)
    );

    serial_tx_sched #(.N_REQ(4), .WIDTH(4), .GAP(0)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave),
        .so(so2), .so_en(so_en2), .busy(busy2), .grant_id(gid2), .frame_done(fd2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts on the first bit cycle of a WIDTH=8 frame, ends on the following IDLE cycle.
    task automatic shift_word1(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            check("so", so1, w[i]);
            check("so_en", so_en1, 1);
            check("frame_done", fd1, (i == 0));
            check("busy_shift", busy1, 1);
            check("ready_in_shift", bus1.req_ready, 0);
            tick();
        end
        check("gap_so_en", so_en1, 0);
        check("gap_busy", busy1, 1);
        check("gap_frame_done", fd1, 0);
        check("ready_in_gap", bus1.req_ready, 0);
        tick();
        check("idle_busy", busy1, 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        check("rst_so", so1, 0);
        check("rst_so_en", so_en1, 0);
        check("rst_busy", busy1, 0);
        check("rst_frame_done", fd1, 0);
        check("rst_grant_id", gid1, 3);
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        bus1.req_valid = '0;
        bus1.req_data  = '0;
        bus2.req_valid = '0;
        bus2.req_data  = '0;
        tick();
        tick();
        check("reset_so", so1, 0);
        check("reset_so_en", so_en1, 0);
        check("reset_busy", busy1, 0);
        check("reset_frame_done", fd1, 0);
        check("reset_ready", bus1.req_ready, 0);
        check("reset_grant_id", gid1, 3);
        check("reset2_grant_id", gid2, 3);
        reset = 1'b0;
        tick();

        // Single word from requester 0.
        bus1.req_data[7:0] = 8'hA5;
        bus1.req_valid     = 4'b0001;
        #1;
        check("single_ready", bus1.req_ready, 4'b0001);
        tick();
        bus1.req_valid = '0;
        shift_word1(8'hA5);
        check("single_grant_id", gid1, 0);
        check("single_ready_after", bus1.req_ready, 0);

        // Round-robin with all four valid; reset first so grant_id starts at 3.
        pulse_reset();
        bus1.req_data  = {8'h08, 8'h04, 8'h02, 8'h01};
        bus1.req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rr_ready", bus1.req_ready, 32'(1 << k));
            tick();
            check("rr_grant_id", gid1, k);
            bus1.req_valid[k] = 1'b0;
            shift_word1(8'(1 << k));
        end

        // Wrap: move pointer to 2, then 0 and 3 compete -> 3 then 0.
        bus1.req_data[23:16] = 8'h5A;
        bus1.req_valid       = 4'b0100;
        #1;
        check("wrap_pre_ready", bus1.req_ready, 4'b0100);
        tick();
        bus1.req_valid = '0;
        shift_word1(8'h5A);
        check("wrap_pre_gid", gid1, 2);
        bus1.req_data[7:0]   = 8'hC3;
        bus1.req_data[31:24] = 8'h96;
        bus1.req_valid       = 4'b1001;
        #1;
        check("wrap_ready3", bus1.req_ready, 4'b1000);
        tick();
        bus1.req_valid[3] = 1'b0;
        shift_word1(8'h96);
        check("wrap_ready0", bus1.req_ready, 4'b0001);
        tick();
        bus1.req_valid[0] = 1'b0;
        shift_word1(8'hC3);
        check("wrap_gid0", gid1, 0);

        // No requests for 50 cycles.
        for (int c = 0; c < 50; c++) begin
            check("norq_ready", bus1.req_ready, 0);
            check("norq_so_en", so_en1, 0);
            check("norq_busy", busy1, 0);
            check("norq_gid", gid1, 0);
            tick();
        end

        // Reset mid-frame after three bits of 8'hFF.
        bus1.req_data[7:0] = 8'hFF;
        bus1.req_valid     = 4'b0001;
        #1;
        check("mid_ready", bus1.req_ready, 4'b0001);
        tick();
        bus1.req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            check("mid_so", so1, 1);
            check("mid_so_en", so_en1, 1);
            if (i < 2) tick();
        end
        pulse_reset();
        check("post_rst_busy", busy1, 0);
        bus1.req_data[7:0]  = 8'h3C;
        bus1.req_data[15:8] = 8'hE1;
        bus1.req_valid      = 4'b0011;
        #1;
        check("post_rst_ready0", bus1.req_ready, 4'b0001);
        tick();
        bus1.req_valid[0] = 1'b0;
        shift_word1(8'h3C);
        check("post_rst_ready1", bus1.req_ready, 4'b0010);
        tick();
        bus1.req_valid[1] = 1'b0;
        shift_word1(8'hE1);

        // GAP=0, WIDTH=4 instance: requester 1 holds 4'hC valid continuously.
        bus2.req_data[7:4] = 4'hC;
        bus2.req_valid     = 4'b0010;
        #1;
        for (int f = 0; f < 3; f++) begin
            check("g0_ready", bus2.req_ready, 4'b0010);
            check("g0_idle_so_en", so_en2, 0);
            check("g0_idle_busy", busy2, 0);
            tick();
            check("g0_gid", gid2, 1);
            for (int i = 3; i >= 0; i--) begin
                check("g0_so", so2, (i >= 2));
                check("g0_so_en", so_en2, 1);
                check("g0_frame_done", fd2, (i == 0));
                check("g0_ready_shift", bus2.req_ready, 0);
                tick();
            end
        end
        bus2.req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_tx_sched.md
# serial_tx_sched

Round-robin scheduler that shares one serial shift-out datapath among N parallel requesters. Each requester offers a WIDTH-bit word with a valid/ready handshake. The block grants one requester at a time, loads its word into the internal shift register, and shifts it out MSB-first on a single serial line. A configurable idle gap follows each frame. It sits between the parallel producers and the serial link pin.

## Interface
- N_REQ, 4, number of requesters (2..16)
- WIDTH, 8, bits per word / shift-register length (2..32)
- GAP, 1, idle cycles inserted after each frame (0..15)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  N_REQ  requester i has a word pending
- req_data  in  N_REQ*WIDTH  word of requester i at bits [i*WIDTH +: WIDTH]
- req_ready  out  N_REQ  one-hot accept strobe; word i consumed on this cycle
- so  out  1  serial data out, MSB first
- so_en  out  1  high on every cycle that so carries a valid data bit
- busy  out  1  high in SHIFT or GAP
- grant_id  out  $clog2(N_REQ)  index of the most recently granted requester
- frame_done  out  1  one-cycle pulse on the cycle carrying the last bit (LSB)

## Operation
- States: IDLE, SHIFT, GAP. Reset state IDLE.
- Reset values: so=0, so_en=0, busy=0, frame_done=0, req_ready=0, grant_id=N_REQ-1, shift register=0, bit counter=0.
- IDLE:
  - If any req_valid is high, the arbiter picks a winner by searching from (grant_id+1) mod N_REQ upward with wrap.
  - req_ready[winner]=1 combinationally in the same cycle.
  - At the clock edge: load the winner's word into the shift register, set grant_id=winner, clear the bit counter, go to SHIFT.
  - If no req_valid is high: stay in IDLE with all req_ready=0.
- SHIFT:
  - so = shift register MSB, so_en=1.
  - Each cycle: shift left, filling with 0; increment the counter.
  - On the cycle with counter=WIDTH-1: frame_done=1. At that edge go to GAP if GAP>0, else to IDLE.
- GAP: so=0, so_en=0, busy=1. Count GAP cycles, then go to IDLE.
- req_ready is asserted only in IDLE. It is never asserted in SHIFT or GAP, even when valids are pending.
- Requester rules:
  - Hold req_valid and req_data stable until req_ready.
  - A requester may raise valid at any time.
  - The block does not check for valid being dropped early.
- so, so_en and frame_done are registered outputs. req_ready is combinational from state, req_valid and grant_id.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). The partially sent word is discarded and not re-requested. Arbitration restarts with requester 0 highest priority.

## Timing
- Accept at cycle t (IDLE, req_ready[i]=1).
- Bits appear on cycles t+1 .. t+WIDTH, MSB at t+1.
- frame_done is high at t+WIDTH.
- GAP occupies cycles t+WIDTH+1 .. t+WIDTH+GAP.
- Next accept is possible at cycle t+WIDTH+GAP+1.
- Sustained throughput is one word per WIDTH+GAP+1 cycles. The IDLE cycle is mandatory, even when GAP=0.
- Requests that arrive during SHIFT/GAP wait; latency is bounded by N_REQ frames.
- Simultaneous valids: exactly one ready per accept cycle, in round-robin order.

## Structure
- Package serial_tx_sched_pkg:
  - state enum (IDLE, SHIFT, GAP)
  - function for the grant-index width
  - bit-counter width constant.
- Sub-module rr_arbiter (N_REQ parameter): inputs req vector, last grant and enable; output is a one-hot grant plus the encoded index. It is purely combinational. The pointer register lives in the parent.
- The shift register, counters and FSM stay in serial_tx_sched.

## Test plan
- Single word: requester 0 sends 8'hA5 with defaults → req_ready[0] for 1 cycle; so = 1,0,1,0,0,1,0,1 on the next 8 cycles with so_en=1; frame_done on the 8th; one GAP cycle; busy=0 afterwards.
- Round-robin: all 4 valid with data 8'h01, 8'h02, 8'h04, 8'h08 → grants in order 0,1,2,3; accepts spaced 10 cycles apart; each word serialized intact.
- Wrap and fairness: after grant_id=2, requesters 0 and 3 valid → 3 granted first, then 0.
- GAP=0, WIDTH=4, requester 1 valid continuously with 4'hC → accepts every 5 cycles; so_en low exactly on the IDLE cycle.
- Reset mid-frame: assert reset after 3 bits of 8'hFF → so/so_en/busy go to 0 immediately; after release, requester 0 is granted before 1 when both are valid.
- No request: valids all 0 for 50 cycles → req_ready=0, so_en=0, busy=0, grant_id unchanged.
